// File: rtl/et_run_scheduler.sv
// Sequencer for one stochastic-computing evaluation run with early termination.
// It seeds the datapath LFSR, enables the datapath, counts the output stream and returns the ones/length result.
module et_run_scheduler #(
    parameter int CTR_WIDTH  = 5,
    parameter int LEN_WIDTH  = 8,
    parameter int SEED_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [CTR_WIDTH-1:0]  nmin,
    input  logic [LEN_WIDTH-1:0]  max_len,
    input  logic [SEED_WIDTH-1:0] seed,
    output logic                  lfsr_load,
    output logic [SEED_WIDTH-1:0] seed_out,
    output logic                  sc_en,
    input  logic                  pz,
    input  logic                  z_bit,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [LEN_WIDTH-1:0]  res_ones,
    output logic [LEN_WIDTH-1:0]  res_len,
    output logic                  res_early
);

    typedef enum logic [1:0] {IDLE, SEED, RUN, RESP} state_t;

    state_t                state;
    logic [CTR_WIDTH-1:0]  nmin_q;
    logic [LEN_WIDTH-1:0]  max_len_q;
    logic [SEED_WIDTH-1:0] seed_q;
    logic [CTR_WIDTH-1:0]  et_ctr;
    logic [LEN_WIDTH-1:0]  len_ctr;
    logic [LEN_WIDTH-1:0]  ones_ctr;
    logic                  pz_prev;

    logic                  rise;
    logic                  et_hit;
    logic                  len_hit;
    logic [LEN_WIDTH-1:0]  len_next;
    logic [LEN_WIDTH-1:0]  ones_next;
    logic [CTR_WIDTH+1:0]  et_sum;
    logic [CTR_WIDTH-1:0]  et_bumped;

    assign seed_out  = seed_q;
    assign rise      = pz & ~pz_prev;
    assign len_next  = len_ctr + 1'b1;
    assign ones_next = ones_ctr + LEN_WIDTH'(z_bit);
    assign et_hit    = (et_ctr == '0);
    assign len_hit   = (len_next == max_len_q);

    // Two guard bits keep et_ctr+3 exact before clamping to the all-ones ceiling.
    assign et_sum    = {2'b00, et_ctr} + (CTR_WIDTH+2)'(3);
    assign et_bumped = (et_sum > {2'b00, {CTR_WIDTH{1'b1}}}) ? {CTR_WIDTH{1'b1}}
                                                              : et_sum[CTR_WIDTH-1:0];

    // NOTE: every register here uses <= so all of them see pre-edge values, which the
    // same-cycle termination test on pre-update counters relies on.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            lfsr_load   <= 1'b0;
            sc_en       <= 1'b0;
            res_valid   <= 1'b0;
            res_ones    <= '0;
            res_len     <= '0;
            res_early   <= 1'b0;
            nmin_q      <= '0;
            max_len_q   <= '0;
            seed_q      <= '0;
            et_ctr      <= '0;
            len_ctr     <= '0;
            ones_ctr    <= '0;
            pz_prev     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid && start_ready) begin
                        nmin_q      <= nmin;
                        max_len_q   <= (max_len == '0) ? LEN_WIDTH'(1) : max_len;
                        seed_q      <= seed;
                        start_ready <= 1'b0;
                        lfsr_load   <= 1'b1;
                        state       <= SEED;
                    end
                end
                SEED: begin
                    lfsr_load <= 1'b0;
                    sc_en     <= 1'b1;
                    et_ctr    <= nmin_q;
                    len_ctr   <= '0;
                    ones_ctr  <= '0;
                    pz_prev   <= 1'b0;
                    state     <= RUN;
                end
                RUN: begin
                    len_ctr  <= len_next;
                    ones_ctr <= ones_next;
                    pz_prev  <= pz;
                    if (rise) begin
                        et_ctr <= et_bumped;
                    end else if (!et_hit) begin
                        et_ctr <= et_ctr - 1'b1;
                    end
                    if (et_hit || len_hit) begin
                        sc_en     <= 1'b0;
                        res_valid <= 1'b1;
                        res_ones  <= ones_next;
                        res_len   <= len_next;
                        res_early <= et_hit & ~len_hit;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        start_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_et_run_scheduler.sv
// Scoreboard bench for et_run_scheduler: directed runs push expected results,
// and a monitor pops and compares them at every result handshake.
module tb_et_run_scheduler;

    localparam int CW = 5;
    localparam int LW = 8;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic [CW-1:0] nmin = '0;
    logic [LW-1:0] max_len = '0;
    logic [SW-1:0] seed = '0;
    logic          lfsr_load;
    logic [SW-1:0] seed_out;
    logic          sc_en;
    logic          pz = 1'b0;
    logic          z_bit = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [LW-1:0] res_ones;
    logic [LW-1:0] res_len;
    logic          res_early;

    et_run_scheduler #(.CTR_WIDTH(CW), .LEN_WIDTH(LW), .SEED_WIDTH(SW)) dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .nmin(nmin), .max_len(max_len), .seed(seed),
        .lfsr_load(lfsr_load), .seed_out(seed_out), .sc_en(sc_en),
        .pz(pz), .z_bit(z_bit),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_ones(res_ones), .res_len(res_len), .res_early(res_early)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LW-1:0] ones;
        logic [LW-1:0] len;
        logic          early;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Per-run datapath pattern: pz steps high from RUN cycle pz_rise_at (-1 = never);
    // z_mode 0 = all ones, 1 = alternating starting with 1, 2 = all zeros.
    int   pz_rise_at = -1;
    int   z_mode     = 0;
    int   run_k      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sc_en) begin
            pz    = (pz_rise_at >= 0) && (run_k >= pz_rise_at);
            z_bit = (z_mode == 0) ? 1'b1 : (z_mode == 1) ? (run_k % 2 == 0) : 1'b0;
            run_k++;
        end else begin
            run_k = 0;
            pz    = 1'b0;
            z_bit = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got ones=%0d len=%0d with empty scoreboard", res_ones, res_len);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_ones", res_ones, e.ones);
                check("res_len", res_len, e.len);
                check("res_early", res_early, e.early);
            end
        end
    end

    task automatic do_run(input int n, input int ml, input int sd, input int rise_at,
                          input int zm, input int e_ones, input int e_len, input int e_early,
                          input int hold);
        exp_t e;
        int   cyc;
        @(negedge clk);
        pz_rise_at  = rise_at;
        z_mode      = zm;
        nmin        = CW'(n);
        max_len     = LW'(ml);
        seed        = SW'(sd);
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        check("lfsr_load_pulse", lfsr_load, 1);
        check("seed_out", seed_out, sd);
        e.ones  = LW'(e_ones);
        e.len   = LW'(e_len);
        e.early = e_early[0];
        sb.push_back(e);
        cyc = 1;
        while (!res_valid && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("res_latency", cyc, e_len + 2);
        if (!res_valid) return;
        for (int i = 0; i < hold; i++) begin
            check("hold_ones", res_ones, e_ones);
            check("hold_len", res_len, e_len);
            check("hold_start_ready", start_ready, 0);
            check("hold_no_new_run", {sc_en, lfsr_load}, 0);
            start_valid = (i % 2 == 0);
            @(posedge clk);
            #1;
        end
        start_valid = 1'b0;
        res_ready   = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("res_valid_drop", res_valid, 0);
        check("ready_after_resp", start_ready, 1);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_start_ready", start_ready, 1);
        check("rst_outputs_zero", {lfsr_load, sc_en, res_valid, res_early}, 0);
        check("rst_res_len", res_len, 0);
        rst = 1'b0;

        // nmin, max_len, seed, pz_rise_at, z_mode, ones, len, early, hold
        do_run(4,  20,  8'hA5, -1, 0,  5,  5, 1, 0);  // basic ET run
        do_run(2,  50,  8'h3C,  1, 2,  0,  7, 1, 0);  // one +3 from a pz rise
        do_run(31, 10,  8'h11, -1, 1,  5, 10, 0, 0);  // length cap
        do_run(30, 200, 8'h77,  0, 1, 17, 33, 1, 0);  // saturation at 31
        do_run(3,  4,   8'h01, -1, 0,  4,  4, 0, 0);  // coincident hits
        do_run(0,  9,   8'h02, -1, 0,  1,  1, 1, 0);  // nmin=0
        do_run(0,  0,   8'h03, -1, 0,  1,  1, 0, 0);  // nmin=0, max_len=0
        do_run(1,  20,  8'hC3, -1, 1,  1,  2, 1, 5);  // backpressure

        // Reset during RUN cycle 3: the run is abandoned and nothing is pushed.
        @(negedge clk);
        pz_rise_at  = -1;
        z_mode      = 0;
        nmin        = CW'(31);
        max_len     = LW'(200);
        seed        = SW'(8'h5A);
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("midrun_sc_en", sc_en, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_sc_en", sc_en, 0);
        check("rst_mid_res_valid", res_valid, 0);
        check("rst_mid_start_ready", start_ready, 1);

        do_run(5, 0, 8'h99, -1, 0, 1, 1, 0, 0);      // follow-up: max_len=0 acts as 1

        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/et_run_scheduler.md
Name: et_run_scheduler

Overview:
- Controller that sequences one stochastic-computing (SC) evaluation run with variable early termination (ET).
- Accepts a run request over a valid/ready handshake and loads the datapath's LFSR seed.
- Enables the SC datapath and accumulates its output bitstream.
- Stops the run on ET countdown expiry or on the maximum stream length, then returns the ones count and stream length over a valid/ready handshake.

Parameters:
- CTR_WIDTH, 5, width of the ET countdown counter and the nmin input.
- LEN_WIDTH, 8, width of the max_len, length and ones counters.
- SEED_WIDTH, 8, width of the LFSR seed passed to the datapath.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_valid  in  1  run request valid.
- start_ready  out  1  scheduler can accept a request.
- nmin  in  CTR_WIDTH  initial ET countdown value.
- max_len  in  LEN_WIDTH  maximum stream length in cycles; 0 is treated as 1.
- seed  in  SEED_WIDTH  LFSR seed for the run.
- lfsr_load  out  1  one-cycle load strobe to the datapath LFSR.
- seed_out  out  SEED_WIDTH  latched seed, valid while lfsr_load is high.
- sc_en  out  1  datapath advance enable.
- pz  in  1  datapath progress indicator, sampled only while sc_en is high.
- z_bit  in  1  datapath output stream bit, sampled only while sc_en is high.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts the result.
- res_ones  out  LEN_WIDTH  number of z_bit ones in the run.
- res_len  out  LEN_WIDTH  number of RUN cycles.
- res_early  out  1  run ended by ET before reaching max_len.

Behaviour:
- Reset (synchronous, rst high):
  - State goes to IDLE.
  - All outputs go to 0 except start_ready, which is 1.
  - All internal counters and latches go to 0.
  - Reset overrides any state, including mid-RUN and mid-RESP. The pending result is discarded.
- State IDLE:
  - start_ready=1.
  - On start_valid&start_ready, latch nmin, max_len (0 becomes 1) and seed, then go to SEED.
- State SEED (exactly 1 cycle):
  - lfsr_load=1, seed_out=latched seed, sc_en=0.
  - Initialise et_ctr=nmin, len_ctr=0, ones_ctr=0, pz_prev=0.
  - Go to RUN.
- State RUN (sc_en=1 every cycle). Each cycle:
  - len_ctr += 1 and ones_ctr += z_bit.
  - rise = pz & ~pz_prev; then pz_prev <= pz.
  - ET counter update:
    - if rise: et_ctr <= min(et_ctr+3, 2^CTR_WIDTH-1), saturating;
    - else if et_ctr != 0: et_ctr <= et_ctr-1;
    - else hold.
  - Termination is evaluated in the same cycle, on pre-update values, with the current sample counted:
    - et_hit = (et_ctr==0)
    - len_hit = (len_ctr+1 == max_len)
  - If et_hit or len_hit, go to RESP.
  - res_early = et_hit & ~len_hit. When both hit together, res_early=0.
  - No wrap: len_ctr cannot exceed max_len ≤ 2^LEN_WIDTH-1, so ones_ctr never overflows.
- State RESP:
  - res_valid=1; res_ones, res_len and res_early are held stable; sc_en=0; start_ready=0.
  - On res_valid&res_ready, go to IDLE.
  - res_valid drops in the next cycle; result outputs may keep their last values.
- start_ready is 0 outside IDLE. start_valid is ignored there.
- Latency: request accepted in cycle t; SEED runs in t+1; RUN occupies t+2..t+1+res_len; res_valid rises in t+2+res_len.
- nmin=0: et_hit occurs on the first RUN cycle, so res_len=1; res_early=1 unless max_len ≤ 1.

Test Plan:
- Basic ET run:
  - Stimulus: nmin=4, max_len=20, pz=0, z_bit=1.
  - Response: 5 RUN cycles; res_len=5, res_ones=5, res_early=1; res_valid 7 cycles after acceptance.
- Rising-edge extension:
  - Stimulus: nmin=2; pz goes 0→1 on RUN cycle 1 and stays high.
  - Response: et_ctr sequence 2,1→4,3,2,1,0; res_len=7; exactly one +3 applied.
- Length cap:
  - Stimulus: nmin=31, pz=0, max_len=10, z_bit alternating starting at 1.
  - Response: res_len=10, res_ones=5, res_early=0.
- Saturation and coincident hits:
  - Stimulus A: CTR_WIDTH=5, nmin=30, pz rises on RUN cycle 0.
  - Response A: et_ctr becomes 31.
  - Stimulus B: nmin=3, max_len=4, pz=0.
  - Response B: both hits on cycle 4; res_len=4, res_early=0.
- Backpressure:
  - Stimulus: hold res_ready=0 for 5 cycles in RESP while pulsing start_valid.
  - Response: result outputs stable; start_ready=0; no new run starts until after the handshake.
- Reset mid-run:
  - Stimulus: assert rst in RUN cycle 3.
  - Response: next cycle IDLE, sc_en=0, res_valid=0, start_ready=1.
  - Follow-up: a new request with max_len=0 yields res_len=1.
